rca_pipe_addsub: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor with valid/ready handshakes on the operand and result sides. The operand word is split into `NUM_STAGES = DATA_SIZE/STAGE_WIDTH` chunks. Each pipeline stage adds one chunk and registers its carry into the next stage, giving one result per cycle at any width. It sits between the operand FIFO and the result FIFO in the ALU datapath and adds a subtract mode, signed-overflow flag and backpressure stalling.

---
 rtl/rca_pipe_addsub.sv | 131 +++++++++++++
 tb/tb_rca_pipe_addsub.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor: one STAGE_WIDTH chunk per stage,
// valid/ready handshakes, and a global stall driven by result backpressure.
module rca_pipe_addsub #(
  parameter int DATA_SIZE   = 32,
  parameter int STAGE_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] add_1,
  input  logic [DATA_SIZE-1:0] add_2,
  input  logic                 c_in,
  input  logic                 sub,
  input  logic                 a_valid_f_data,
  output logic                 a_ready_f_data,
  output logic [DATA_SIZE-1:0] s,
  output logic                 c_out,
  output logic                 ovf,
  output logic                 a_valid_f_res,
  input  logic                 a_ready_f_res
);

  localparam int NUM_STAGES = DATA_SIZE / STAGE_WIDTH;
  localparam int MSB        = DATA_SIZE - 1;

  logic                 en;
  logic [DATA_SIZE-1:0] a_in_r;
  logic [DATA_SIZE-1:0] b_in_r;
  logic                 c_in_r;
  logic                 v_in_r;

  // x_r: finished sum chunks below the stage boundary, untouched A chunks above.
  logic [DATA_SIZE-1:0] x_r  [NUM_STAGES];
  logic [DATA_SIZE-1:0] y_r  [NUM_STAGES];
  logic                 c_r  [NUM_STAGES];
  logic                 v_r  [NUM_STAGES];
  logic                 am_r [NUM_STAGES];

  logic [DATA_SIZE-1:0] s_r;
  logic                 c_out_r;
  logic                 ovf_r;
  logic                 vld_r;

  assign en             = !vld_r || a_ready_f_res;
  assign a_ready_f_data = en;

  // Operand register: subtract is folded into B' and cin' here.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_in_r <= '0;
      b_in_r <= '0;
      c_in_r <= 1'b0;
      v_in_r <= 1'b0;
    end else if (en) begin
      a_in_r <= add_1;
      b_in_r <= sub ? ~add_2 : add_2;
      c_in_r <= sub ? ~c_in : c_in;
      v_in_r <= a_valid_f_data;
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int LO = k * STAGE_WIDTH;

    logic [DATA_SIZE-1:0] x_in;
    logic [DATA_SIZE-1:0] y_in;
    logic [DATA_SIZE-1:0] x_nxt;
    logic                 c_prev;
    logic                 v_prev;
    logic [STAGE_WIDTH:0] chunk;

    if (k == 0) begin : g_head
      assign x_in   = a_in_r;
      assign y_in   = b_in_r;
      assign c_prev = c_in_r;
      assign v_prev = v_in_r;
    end else begin : g_tail
      assign x_in   = x_r[k-1];
      assign y_in   = y_r[k-1];
      assign c_prev = c_r[k-1];
      assign v_prev = v_r[k-1];
    end

    assign chunk = {1'b0, x_in[LO +: STAGE_WIDTH]} + {1'b0, y_in[LO +: STAGE_WIDTH]}
                 + {{STAGE_WIDTH{1'b0}}, c_prev};

    // Splice this stage's sum chunk into the travelling word.
    always_comb begin
      x_nxt = x_in;
      x_nxt[LO +: STAGE_WIDTH] = chunk[STAGE_WIDTH-1:0];
    end

    // Stage register; A's MSB is kept aside because the last stage overwrites it.
    always_ff @(posedge clk) begin
      if (rst) begin
        x_r[k]  <= '0;
        y_r[k]  <= '0;
        c_r[k]  <= 1'b0;
        v_r[k]  <= 1'b0;
        am_r[k] <= 1'b0;
      end else if (en) begin
        x_r[k]  <= x_nxt;
        y_r[k]  <= y_in;
        c_r[k]  <= chunk[STAGE_WIDTH];
        v_r[k]  <= v_prev;
        am_r[k] <= x_in[MSB];
      end
    end
  end

  // Result register: holds stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_r     <= '0;
      c_out_r <= 1'b0;
      ovf_r   <= 1'b0;
      vld_r   <= 1'b0;
    end else if (en) begin
      s_r     <= x_r[NUM_STAGES-1];
      c_out_r <= c_r[NUM_STAGES-1];
      ovf_r   <= (am_r[NUM_STAGES-1] == y_r[NUM_STAGES-1][MSB]) &&
                 (x_r[NUM_STAGES-1][MSB] != am_r[NUM_STAGES-1]);
      vld_r   <= v_r[NUM_STAGES-1];
    end
  end

  assign s             = s_r;
  assign c_out         = c_out_r;
  assign ovf           = ovf_r;
  assign a_valid_f_res = vld_r;

endmodule

// File: tb/tb_rca_pipe_addsub.sv
// Self-checking bench for rca_pipe_addsub: directed corner cases, random streams
// with backpressure and reset, plus an 8-bit sweep over three stage widths.
module tb_rca_pipe_addsub;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ov;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] add_1, add_2, s;
  logic        c_in, sub, vin, rdy_d, c_out, ovf, vout, rready;

  logic [7:0]  a8, b8, s_n1, s_n4, s_n8;
  logic        c8, sub8, v8, rr8;
  logic        co_n1, co_n4, co_n8, ov_n1, ov_n4, ov_n8;
  logic        vo_n1, vo_n4, vo_n8, rd_n1, rd_n4, rd_n8;

  int   n_vec = 0;
  int   n_err = 0;
  res_t exp_q[$];
  res_t got_q[$];
  res_t e1_q[$];
  res_t e4_q[$];
  res_t e8_q[$];

  always #5 clk = ~clk;

  rca_pipe_addsub dut (
    .clk(clk), .rst(rst), .add_1(add_1), .add_2(add_2), .c_in(c_in), .sub(sub),
    .a_valid_f_data(vin), .a_ready_f_data(rdy_d), .s(s), .c_out(c_out), .ovf(ovf),
    .a_valid_f_res(vout), .a_ready_f_res(rready));

  rca_pipe_addsub #(.DATA_SIZE(8), .STAGE_WIDTH(1)) dut_n1 (
    .clk(clk), .rst(rst), .add_1(a8), .add_2(b8), .c_in(c8), .sub(sub8),
    .a_valid_f_data(v8), .a_ready_f_data(rd_n1), .s(s_n1), .c_out(co_n1), .ovf(ov_n1),
    .a_valid_f_res(vo_n1), .a_ready_f_res(rr8));

  rca_pipe_addsub #(.DATA_SIZE(8), .STAGE_WIDTH(4)) dut_n4 (
    .clk(clk), .rst(rst), .add_1(a8), .add_2(b8), .c_in(c8), .sub(sub8),
    .a_valid_f_data(v8), .a_ready_f_data(rd_n4), .s(s_n4), .c_out(co_n4), .ovf(ov_n4),
    .a_valid_f_res(vo_n4), .a_ready_f_res(rr8));

  rca_pipe_addsub #(.DATA_SIZE(8), .STAGE_WIDTH(8)) dut_n8 (
    .clk(clk), .rst(rst), .add_1(a8), .add_2(b8), .c_in(c8), .sub(sub8),
    .a_valid_f_data(v8), .a_ready_f_data(rd_n8), .s(s_n8), .c_out(co_n8), .ovf(ov_n8),
    .a_valid_f_res(vo_n8), .a_ready_f_res(rr8));

  // Reference: integer arithmetic and signed range check, independent of any chunking.
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sb);
    longint m, half, r, sa, sbv, r2;
    res_t   res;
    m    = longint'(1) << w;
    half = m / 64'sd2;
    r    = sb ? (longint'(a) - longint'(b) - longint'(ci))
              : (longint'(a) + longint'(b) + longint'(ci));
    sa   = (longint'(a) >= half) ? longint'(a) - m : longint'(a);
    sbv  = (longint'(b) >= half) ? longint'(b) - m : longint'(b);
    r2   = sb ? (sa - sbv - longint'(ci)) : (sa + sbv + longint'(ci));
    res.s  = 32'(r & (m - 64'sd1));
    res.co = sb ? (r >= 64'sd0) : (r >= m);
    res.ov = (r2 >= half) || (r2 < -half);
    return res;
  endfunction

  // Scoreboard feed for the 32-bit instance; reset discards everything in flight.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (vout && rready) got_q.push_back({s, c_out, ovf});
      if (vin && rdy_d) exp_q.push_back(model(32, add_1, add_2, c_in, sub));
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; vin = 1'b1; add_1 = 32'h1234_5678; add_2 = 32'h0000_0001;
    c_in = 1'b0; sub = 1'b0; rready = 1'b1;
    step();
    step();
    rst = 1'b0; vin = 1'b0;
    n_vec++; if (vout !== 1'b0)  begin n_err++; $display("FAIL reset_valid got %b want 0", vout); end
    n_vec++; if (s !== 32'h0)    begin n_err++; $display("FAIL reset_s got %h want 0", s); end
    n_vec++; if (c_out !== 1'b0) begin n_err++; $display("FAIL reset_cout got %b want 0", c_out); end
    n_vec++; if (ovf !== 1'b0)   begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
    n_vec++; if (rdy_d !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", rdy_d); end
    n_vec++;
    if ({vo_n1, vo_n4, vo_n8} !== 3'b000) begin
      n_err++; $display("FAIL reset_valid8 got %b want 000", {vo_n1, vo_n4, vo_n8});
    end
    repeat (8) step();
    n_vec++;
    if (got_q.size() !== 0) begin
      n_err++; $display("FAIL reset_beat_accepted got %0d results want 0", got_q.size());
    end
  endtask

  task automatic test_single(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic ci, input logic sb, input logic [31:0] es,
                             input logic eco, input logic eov);
    int lat;
    got_q.delete();
    add_1 = a; add_2 = b; c_in = ci; sub = sb; vin = 1'b1; rready = 1'b1;
    step();
    vin = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      step();
      if (vout) lat = k;
    end
    n_vec++; if (lat != 5)    begin n_err++; $display("FAIL %s latency got %0d want 5", name, lat); end
    n_vec++; if (s !== es)    begin n_err++; $display("FAIL %s s got %h want %h", name, s, es); end
    n_vec++; if (c_out !== eco) begin n_err++; $display("FAIL %s c_out got %b want %b", name, c_out, eco); end
    n_vec++; if (ovf !== eov) begin n_err++; $display("FAIL %s ovf got %b want %b", name, ovf, eov); end
    step();
    n_vec++; if (vout !== 1'b0) begin n_err++; $display("FAIL %s valid_one_cycle got %b want 0", name, vout); end
  endtask

  task automatic test_stream();
    int   first, last, cnt;
    res_t g, e;
    got_q.delete(); exp_q.delete();
    rready = 1'b1; first = -1; last = -1; cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (k < 16) begin
        add_1 = $urandom; add_2 = $urandom;
        c_in = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1)); vin = 1'b1;
      end else begin
        vin = 1'b0;
      end
      step();
      if (vout) begin
        if (first < 0) first = k;
        last = k; cnt++;
      end
    end
    n_vec++; if (first != 5) begin n_err++; $display("FAIL stream_first got %0d want 5", first); end
    n_vec++; if (cnt != 16)  begin n_err++; $display("FAIL stream_count got %0d want 16", cnt); end
    n_vec++; if (last != 20) begin n_err++; $display("FAIL stream_last got %0d want 20", last); end
    n_vec++; if (exp_q.size() != 16) begin n_err++; $display("FAIL stream_accepted got %0d want 16", exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_vec++; if (g !== e) begin n_err++; $display("FAIL stream_data got %h want %h", g, e); end
    end
  endtask

  task automatic test_back_to_back_backpressure();
    int          idx, k;
    logic        need_new, acc;
    logic [31:0] snap_s;
    logic        snap_co, snap_ov;
    res_t        g, e;
    got_q.delete(); exp_q.delete();
    idx = 0; k = 0; need_new = 1'b1; rready = 1'b1;
    snap_s = 32'h0; snap_co = 1'b0; snap_ov = 1'b0;
    while (idx < 20 && k < 60) begin
      rready = !(k >= 8 && k <= 13);
      if (need_new) begin
        add_1 = $urandom; add_2 = $urandom;
        c_in = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        need_new = 1'b0;
      end
      vin = 1'b1;
      #1;
      if (k == 8) begin snap_s = s; snap_co = c_out; snap_ov = ovf; end
      if (k >= 8 && k <= 13) begin
        n_vec++; if (rdy_d !== 1'b0) begin n_err++; $display("FAIL bp_ready k=%0d got %b want 0", k, rdy_d); end
      end
      acc = rdy_d;
      @(posedge clk);
      #1;
      if (acc) begin idx++; need_new = 1'b1; end
      if (k >= 8 && k <= 13) begin
        n_vec++;
        if ({vout, s, c_out, ovf} !== {1'b1, snap_s, snap_co, snap_ov}) begin
          n_err++;
          $display("FAIL bp_hold k=%0d got %b/%h/%b/%b want 1/%h/%b/%b",
                   k, vout, s, c_out, ovf, snap_s, snap_co, snap_ov);
        end
      end
      k++;
    end
    vin = 1'b0; rready = 1'b1;
    for (int t = 0; t < 30 && got_q.size() < 20; t++) step();
    n_vec++; if (got_q.size() != 20) begin n_err++; $display("FAIL bp_delivered got %0d want 20", got_q.size()); end
    n_vec++; if (exp_q.size() != 20) begin n_err++; $display("FAIL bp_accepted got %0d want 20", exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_vec++; if (g !== e) begin n_err++; $display("FAIL bp_data got %h want %h", g, e); end
    end
  endtask

  task automatic test_reset_in_flight();
    got_q.delete(); exp_q.delete();
    rready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      add_1 = $urandom; add_2 = $urandom; c_in = 1'b0; sub = 1'b0; vin = 1'b1;
      step();
    end
    vin = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++; if (vout !== 1'b0) begin n_err++; $display("FAIL flight_valid got %b want 0", vout); end
    repeat (12) step();
    n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL flight_stale got %0d results want 0", got_q.size()); end
    test_single("after_reset", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
  endtask

  task automatic test_sweep_latency();
    int l1, l4, l8;
    a8 = 8'h5A; b8 = 8'hC3; c8 = 1'b1; sub8 = 1'b0; v8 = 1'b1; rr8 = 1'b1;
    step();
    v8 = 1'b0; l1 = 0; l4 = 0; l8 = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (vo_n1 && l1 == 0) l1 = k;
      if (vo_n4 && l4 == 0) l4 = k;
      if (vo_n8 && l8 == 0) l8 = k;
    end
    n_vec++; if (l1 != 9) begin n_err++; $display("FAIL lat_sw1 got %0d want 9", l1); end
    n_vec++; if (l4 != 3) begin n_err++; $display("FAIL lat_sw4 got %0d want 3", l4); end
    n_vec++; if (l8 != 2) begin n_err++; $display("FAIL lat_sw8 got %0d want 2", l8); end
  endtask

  task automatic test_sweep_exhaustive();
    res_t r;
    e1_q.delete(); e4_q.delete(); e8_q.delete();
    rr8 = 1'b1;
    n_vec++;
    if ({rd_n1, rd_n4, rd_n8} !== 3'b111) begin
      n_err++; $display("FAIL sweep_ready got %b want 111", {rd_n1, rd_n4, rd_n8});
    end
    for (int i = 0; i < 65536 + 12; i++) begin
      if (i < 65536) begin
        a8 = 8'(i); b8 = 8'(i >> 8);
        c8 = 1'($urandom_range(0, 1)); sub8 = 1'($urandom_range(0, 1)); v8 = 1'b1;
        r = model(8, {24'h0, a8}, {24'h0, b8}, c8, sub8);
        e1_q.push_back(r); e4_q.push_back(r); e8_q.push_back(r);
      end else begin
        v8 = 1'b0;
      end
      step();
      if (vo_n1) begin
        n_vec++;
        if (e1_q.size() == 0) begin n_err++; $display("FAIL sw1_extra got %h want none", s_n1); end
        else begin
          r = e1_q.pop_front();
          if ({s_n1, co_n1, ov_n1} !== {r.s[7:0], r.co, r.ov}) begin
            n_err++; $display("FAIL sw1_data got %h/%b/%b want %h/%b/%b", s_n1, co_n1, ov_n1, r.s[7:0], r.co, r.ov);
          end
        end
      end
      if (vo_n4) begin
        n_vec++;
        if (e4_q.size() == 0) begin n_err++; $display("FAIL sw4_extra got %h want none", s_n4); end
        else begin
          r = e4_q.pop_front();
          if ({s_n4, co_n4, ov_n4} !== {r.s[7:0], r.co, r.ov}) begin
            n_err++; $display("FAIL sw4_data got %h/%b/%b want %h/%b/%b", s_n4, co_n4, ov_n4, r.s[7:0], r.co, r.ov);
          end
        end
      end
      if (vo_n8) begin
        n_vec++;
        if (e8_q.size() == 0) begin n_err++; $display("FAIL sw8_extra got %h want none", s_n8); end
        else begin
          r = e8_q.pop_front();
          if ({s_n8, co_n8, ov_n8} !== {r.s[7:0], r.co, r.ov}) begin
            n_err++; $display("FAIL sw8_data got %h/%b/%b want %h/%b/%b", s_n8, co_n8, ov_n8, r.s[7:0], r.co, r.ov);
          end
        end
      end
    end
    n_vec++;
    if (e1_q.size() + e4_q.size() + e8_q.size() != 0) begin
      n_err++;
      $display("FAIL sweep_lost got %0d/%0d/%0d pending want 0", e1_q.size(), e4_q.size(), e8_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; add_1 = 32'h0; add_2 = 32'h0; c_in = 1'b0; sub = 1'b0; vin = 1'b0; rready = 1'b1;
    a8 = 8'h0; b8 = 8'h0; c8 = 1'b0; sub8 = 1'b0; v8 = 1'b0; rr8 = 1'b1;
    test_reset();
    test_single("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    test_single("sub_neg",  32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    test_single("ovf_add",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    test_single("sub_bin",  32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFE, 1'b1, 1'b1);
    test_stream();
    test_back_to_back_backpressure();
    test_reset_in_flight();
    test_sweep_latency();
    test_sweep_exhaustive();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
